diag_move_scan: RTL and testbench
=================================

# diag_move_scan

Parametrised diagonal-shift move scanner for the checkers CPU. It takes one board snapshot: mover pieces, opponent pieces and occupancy. For each enabled diagonal direction it produces a per-square step-candidate mask and a jump-candidate mask, one direction per output beat. It uses a single shared diagonal shifter with border fill, replacing the fixed one-direction shift modules. It sits between the board register file and the move-selection logic.

## Interface
Parameters:
- ROWS, 8, board rows.
- COLS, 4, playable squares per row; N = ROWS*COLS.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block idle, request accepted on in_valid & in_ready.
- in_mover  in  N  squares holding the side-to-move's pieces.
- in_opp  in  N  squares holding opponent pieces.
- in_occ  in  N  occupied squares (superset of mover|opp).
- in_dirs  in  4  enabled directions, bit0 UL, bit1 UR, bit2 DL, bit3 DR.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts beat.
- out_dir  out  2  direction of this beat (0 UL, 1 UR, 2 DL, 3 DR).
- out_step  out  N  step-candidate mask.
- out_jump  out  N  jump-candidate mask.
- out_last  out  1  final beat of this request.
- out_any_jump  out  1  OR of out_jump over all beats so far in this request; final value valid with out_last.

## Operation
- Square i: row r = i/COLS, column c = i%COLS. Rows 0 (top) to ROWS-1.
- Neighbour rules for even r:
  - UL = i-COLS
  - UR = i-COLS+1 (needs c<COLS-1)
  - DL = i+COLS
  - DR = i+COLS+1 (needs c<COLS-1)
- Neighbour rules for odd r:
  - UL = i-COLS-1 (needs c>0)
  - UR = i-COLS
  - DL = i+COLS-1 (needs c>0)
  - DR = i+COLS
- Row limits: U directions need r>0; D directions need r<ROWS-1.
- shift(X,d,f)[i] = X[nbr_d(i)], or f when the neighbour does not exist.
- step_d = mover & ~shift(occ,d,1). Borders count as occupied.
- jump_d = mover & shift(opp,d,0) & ~shift(shift(occ,d,1),d,1).
- Input masks are registered on acceptance. Inputs may change afterwards.
- Enabled directions are processed in ascending order. Disabled directions are skipped.
- in_dirs = 0 gives exactly one beat: out_dir=0, masks 0, out_last=1, out_any_jump=0.
- FSM states:
  - IDLE: in_ready=1. On accept, go to S1 with the lowest enabled dir, or ZERO if in_dirs=0.
  - S1: register shift(occ,d,1) and shift(opp,d,0).
  - S2: run the shifter on the registered occ-shift, then register step_d, jump_d, out_dir and out_last (no higher enabled dir remains). Update the any-jump accumulator.
  - HOLD: out_valid=1. On out_ready, go to S1 with the next dir, or IDLE if out_last.
  - ZERO: load the zero beat, go to HOLD.
- The accumulator clears on accept.

## Timing
- Reset values: in_ready=1; out_valid=0; out_dir=0; out_step=0; out_jump=0; out_last=0; out_any_jump=0; FSM in IDLE.
- Request accepted at edge T: out_valid rises after edge T+3. The ZERO path gives out_valid after T+2.
- Beat accepted at edge U: the next beat's out_valid rises after U+3.
- out_valid drops for 2 cycles between beats.
- Output outputs hold stable while out_valid & ~out_ready.
- in_ready is low from the accept edge until the edge that accepts the last beat. in_ready=1 in the cycle after that edge.
- No new request is accepted in the same cycle as the last beat.
- reset_n low at any time (mid-S1/S2/HOLD) immediately forces reset values. The in-flight request is discarded.

## Structure
- Shared package checkers_pkg holds:
  - dir_t enum (DIR_UL=0, DIR_UR, DIR_DL, DIR_DR).
  - BOARD_ROWS=8, BOARD_COLS=4 defaults.
- Sub-module diag_shift: purely combinational, parameters ROWS/COLS; ports X[N], dir[1:0], fill, Y[N]. One instance only, time-shared between S1 and S2.
- Top level contains the FSM, mask registers, direction-select priority logic and the accumulator.

## Test plan
- Accept mover=0x1, occ=0x1, opp=0, dirs=4'b1100. Expect:
  - Beat 1: dir2, step=0x1, jump=0, last=0.
  - Beat 2: dir3, step=0x1, last=1, any_jump=0.
- Accept mover=0x1, opp=0x20, occ=0x21, dirs=4'b1000. Expect one beat: dir3, step=0, jump=0x1, last=1, any_jump=1.
- Accept mover=0x8, occ=0x8, dirs=4'b1111 (square 3 on the border). Expect 4 beats:
  - UL, UR, DR: step=0.
  - DL: step=0x8.
  - All jumps 0.
- Accept dirs=0. Expect a single beat at T+2: dir0, masks 0, last=1. in_ready=1 after the beat handshake.
- Hold out_ready low 5 cycles in HOLD. Outputs must stay constant. in_valid pulses while busy must be ignored.
- Assert reset_n low during S2 of the second direction. Expect all outputs at reset values immediately. A new request after release must give correct results.

Source files
------------

// File: rtl/checkers_pkg.sv
// checkers_pkg: shared direction type and board defaults for the checkers move logic.
package checkers_pkg;
    typedef enum logic [1:0] {
        DIR_UL = 2'd0,
        DIR_UR = 2'd1,
        DIR_DL = 2'd2,
        DIR_DR = 2'd3
    } dir_t;

    localparam int BOARD_ROWS = 8;
    localparam int BOARD_COLS = 4;

    // Lowest enabled direction; DIR_DR when the mask is empty.
    function automatic dir_t lowest_dir(input logic [3:0] m);
        return m[0] ? DIR_UL : m[1] ? DIR_UR : m[2] ? DIR_DL : DIR_DR;
    endfunction
endpackage

// File: rtl/diag_shift.sv
// diag_shift: combinational one-square diagonal shift of a board mask,
// squares without a neighbour in that direction take the fill value.
module diag_shift
    import checkers_pkg::*;
#(
    parameter int ROWS = BOARD_ROWS,
    parameter int COLS = BOARD_COLS,
    localparam int N = ROWS * COLS
) (
    input  logic [N-1:0] X,
    input  logic [1:0]   dir,
    input  logic         fill,
    output logic [N-1:0] Y
);
    for (genvar i = 0; i < N; i++) begin : g_sq
        localparam int R = i / COLS;
        localparam int C = i % COLS;
        localparam int O = R % 2;
        // Odd rows are offset half a square left of even rows.
        localparam logic UP = R > 0;
        localparam logic DN = R < ROWS - 1;
        localparam logic LF = O == 0 || C > 0;
        localparam logic RT = O == 1 || C < COLS - 1;
        localparam int UL = (UP && LF) ? i - COLS - O : 0;
        localparam int UR = (UP && RT) ? i - COLS + 1 - O : 0;
        localparam int DL = (DN && LF) ? i + COLS - O : 0;
        localparam int DR = (DN && RT) ? i + COLS + 1 - O : 0;
        assign Y[i] = dir == 2'd0 ? ((UP && LF) ? X[UL] : fill) :
                      dir == 2'd1 ? ((UP && RT) ? X[UR] : fill) :
                      dir == 2'd2 ? ((DN && LF) ? X[DL] : fill) :
                                    ((DN && RT) ? X[DR] : fill);
    end
endmodule

// File: rtl/diag_move_scan.sv
// diag_move_scan: per-direction step/jump candidate scanner, one enabled
// direction per output beat, built around one time-shared diagonal shifter.
module diag_move_scan
    import checkers_pkg::*;
#(
    parameter int ROWS = BOARD_ROWS,
    parameter int COLS = BOARD_COLS,
    localparam int N = ROWS * COLS
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_mover,
    input  logic [N-1:0] in_opp,
    input  logic [N-1:0] in_occ,
    input  logic [3:0]   in_dirs,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   out_dir,
    output logic [N-1:0] out_step,
    output logic [N-1:0] out_jump,
    output logic         out_last,
    output logic         out_any_jump
);
    typedef enum logic [2:0] {IDLE, S1, S2, HOLD, ZERO} state_t;

    state_t       state;
    dir_t         cur_dir, next_dir, sh_dir;
    logic [3:0]   dirs_r, above;
    logic [N-1:0] mover_r, opp_r, occ_r, occ_sh, opp_sh, sh_x, sh_y, jump_c;
    logic         sh_fill;

    assign above    = dirs_r & (4'b1110 << cur_dir);
    assign next_dir = lowest_dir(above);
    // The opponent shift is prefetched in IDLE/HOLD, leaving S1/S2 for occupancy.
    assign sh_x     = state == S1 ? occ_r : state == S2 ? occ_sh : state == IDLE ? in_opp : opp_r;
    assign sh_dir   = state == IDLE ? lowest_dir(in_dirs) : state == HOLD ? next_dir : cur_dir;
    assign sh_fill  = state == S1 || state == S2;
    assign jump_c   = mover_r & opp_sh & ~sh_y;

    diag_shift #(.ROWS(ROWS), .COLS(COLS)) u_shift (
        .X(sh_x),
        .dir(sh_dir),
        .fill(sh_fill),
        .Y(sh_y)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_dir      <= 2'd0;
            out_step     <= '0;
            out_jump     <= '0;
            out_last     <= 1'b0;
            out_any_jump <= 1'b0;
            cur_dir      <= DIR_UL;
            dirs_r       <= '0;
            mover_r      <= '0;
            opp_r        <= '0;
            occ_r        <= '0;
            occ_sh       <= '0;
            opp_sh       <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    mover_r      <= in_mover;
                    opp_r        <= in_opp;
                    occ_r        <= in_occ;
                    dirs_r       <= in_dirs;
                    cur_dir      <= lowest_dir(in_dirs);
                    opp_sh       <= sh_y;
                    out_any_jump <= 1'b0;
                    in_ready     <= 1'b0;
                    state        <= ~|in_dirs ? ZERO : S1;
                end
                S1: begin
                    occ_sh <= sh_y;
                    state  <= S2;
                end
                S2: begin
                    out_step     <= mover_r & ~occ_sh;
                    out_jump     <= jump_c;
                    out_dir      <= cur_dir;
                    out_last     <= ~|above;
                    out_any_jump <= out_any_jump | (|jump_c);
                    out_valid    <= 1'b1;
                    state        <= HOLD;
                end
                HOLD: if (out_ready) begin
                    out_valid <= 1'b0;
                    if (out_last) begin
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cur_dir <= next_dir;
                        opp_sh  <= sh_y;
                        state   <= S1;
                    end
                end
                ZERO: begin
                    out_dir   <= 2'd0;
                    out_step  <= '0;
                    out_jump  <= '0;
                    out_last  <= 1'b1;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_diag_move_scan.sv
// tb_diag_move_scan: randomized scoreboard bench for diag_move_scan against a
// geometric board model.
module tb_diag_move_scan;
    localparam int ROWS = 8;
    localparam int COLS = 4;
    localparam int N = ROWS * COLS;

    typedef struct packed {
        logic [1:0]   dir;
        logic [N-1:0] step;
        logic [N-1:0] jump;
        logic         last;
        logic         any;
    } beat_t;

    logic         clock, reset_n, in_valid, in_ready, out_valid, out_ready;
    logic [N-1:0] in_mover, in_opp, in_occ, out_step, out_jump;
    logic [3:0]   in_dirs;
    logic [1:0]   out_dir;
    logic         out_last, out_any_jump;

    beat_t sb[$];
    beat_t e;
    int    checks = 0, errors = 0, cyc = 0;
    int    ready_mode = 1;
    int    acc_cnt = 0, acc_cyc = 0, lat_cnt = 0, low_run = 0;
    logic  acc_zero = 1'b0, held = 1'b0, gap_pending = 1'b0, chk_rdy = 1'b0;
    logic [N+N+3:0] snap;

    diag_move_scan #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_mover(in_mover),
        .in_opp(in_opp),
        .in_occ(in_occ),
        .in_dirs(in_dirs),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_dir(out_dir),
        .out_step(out_step),
        .out_jump(out_jump),
        .out_last(out_last),
        .out_any_jump(out_any_jump)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            out_ready = ready_mode == 2 ? ($urandom_range(0, 3) != 0) : (ready_mode == 1);
        end
    end

    // Neighbour by board geometry: moving one row, the column index is kept
    // or moved by one depending on row parity and the horizontal sense.
    function automatic int nbr(input int i, input int d);
        int r, c, nr, nc;
        r  = i / COLS;
        c  = i % COLS;
        nr = d < 2 ? r - 1 : r + 1;
        nc = (r % 2 == 0) ? c + (d % 2) : c - 1 + (d % 2);
        if (nr < 0 || nr >= ROWS || nc < 0 || nc >= COLS) return -1;
        return nr * COLS + nc;
    endfunction

    function automatic logic [N-1:0] shf(input logic [N-1:0] x, input int d, input logic f);
        logic [N-1:0] y;
        int n;
        for (int i = 0; i < N; i++) begin
            n = nbr(i, d);
            if (n < 0) y[i] = f;
            else y[i] = x[n];
        end
        return y;
    endfunction

    task automatic expect_req(input logic [N-1:0] mv, op, oc, input logic [3:0] d);
        beat_t b;
        logic  any;
        int    last_d;
        any    = 1'b0;
        last_d = -1;
        for (int k = 0; k < 4; k++) if (d[k]) last_d = k;
        if (d == 4'd0) begin
            b      = '0;
            b.last = 1'b1;
            sb.push_back(b);
        end
        for (int k = 0; k < 4; k++) begin
            if (d[k]) begin
                b.dir  = 2'(k);
                b.step = mv & ~shf(oc, k, 1'b1);
                b.jump = mv & shf(op, k, 1'b0) & ~shf(shf(oc, k, 1'b1), k, 1'b1);
                any    = any | (|b.jump);
                b.any  = any;
                b.last = k == last_d;
                sb.push_back(b);
            end
        end
    endtask

    task automatic send(input logic [N-1:0] mv, op, oc, input logic [3:0] d);
        int t;
        t = 0;
        while (!in_ready) begin
            @(posedge clock);
            #1;
            t++;
            if (t > 500) begin
                $display("FAIL send_timeout: in_ready=%0d expected 1", in_ready);
                $fatal(1);
            end
        end
        expect_req(mv, op, oc, d);
        in_mover = mv;
        in_opp   = op;
        in_occ   = oc;
        in_dirs  = d;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        acc_cyc  = cyc;
        acc_zero = d == 4'd0;
        acc_cnt++;
        in_mover = N'($urandom);
        in_opp   = N'($urandom);
        in_occ   = N'($urandom);
        in_dirs  = 4'($urandom);
    endtask

    task automatic send_rand();
        logic [N-1:0] mv, op, oc;
        mv = N'($urandom & $urandom);
        op = N'($urandom & $urandom) & ~mv;
        oc = mv | op | N'($urandom & $urandom & $urandom);
        send(mv, op, oc, 4'($urandom_range(0, 15)));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 || !in_ready) begin
            @(posedge clock);
            #1;
            t++;
            if (t > 3000) begin
                $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb.size());
                $fatal(1);
            end
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset_n) begin
            chk("reset_values", {in_ready, out_valid, out_dir, out_step, out_jump, out_last, out_any_jump},
                {1'b1, 1'b0, 2'd0, {N{1'b0}}, {N{1'b0}}, 1'b0, 1'b0});
            held        = 1'b0;
            gap_pending = 1'b0;
            chk_rdy     = 1'b0;
            low_run     = 0;
            lat_cnt     = acc_cnt;
        end else begin
            if (chk_rdy) begin
                chk("idle_after_last", in_ready, 1'b1);
                chk_rdy = 1'b0;
            end
            if (out_valid) begin
                if (acc_cnt != lat_cnt) begin
                    // Edge at which out_valid is first sampled high, counted from the accept edge.
                    chk("first_latency", cyc + 1 - acc_cyc, acc_zero ? 2 : 3);
                    lat_cnt = acc_cnt;
                end else if (gap_pending) begin
                    chk("beat_gap", low_run, 2);
                end
                gap_pending = 1'b0;
                low_run     = 0;
                chk("busy_not_ready", in_ready, 1'b0);
                if (held) chk("hold_stable", {out_dir, out_step, out_jump, out_last, out_any_jump}, snap);
                if (out_ready) begin
                    held = 1'b0;
                    if (sb.size() == 0) begin
                        chk("unexpected_beat", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("beat", {out_dir, out_step, out_jump, out_last, out_any_jump}, e);
                    end
                    if (out_last) chk_rdy = 1'b1;
                    else gap_pending = 1'b1;
                end else begin
                    held = 1'b1;
                    snap = {out_dir, out_step, out_jump, out_last, out_any_jump};
                end
            end else begin
                low_run++;
            end
        end
    end

    initial begin
        int t;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_mover = '0;
        in_opp   = '0;
        in_occ   = '0;
        in_dirs  = '0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;

        send(32'h1, 32'h0, 32'h1, 4'b1100);
        send(32'h1, 32'h20, 32'h21, 4'b1000);
        send(32'h8, 32'h0, 32'h8, 4'b1111);
        send(32'h0, 32'h0, 32'h0, 4'b0000);
        send(32'hFFFF, 32'h0, 32'hFFFF, 4'b0000);
        drain();

        ready_mode = 0;
        send(32'h00F0_0F00, 32'h0F0F_0000, 32'hFFFF_FF00, 4'b0110);
        t = 0;
        while (!out_valid) begin
            @(posedge clock);
            #1;
            t++;
            if (t > 50) begin
                $display("FAIL hold_wait_timeout: out_valid=%0d expected 1", out_valid);
                $fatal(1);
            end
        end
        repeat (5) begin
            in_valid = 1'($urandom_range(0, 1));
            in_dirs  = 4'($urandom);
            in_mover = N'($urandom);
            @(posedge clock);
            #1;
        end
        in_valid   = 1'b0;
        ready_mode = 1;
        drain();

        ready_mode = 2;
        repeat (40) send_rand();
        drain();

        ready_mode = 1;
        send(32'h0000_3300, 32'h0033_0000, 32'h0133_3300, 4'b1111);
        t = 0;
        while (!(out_valid && out_ready)) begin
            @(negedge clock);
            t++;
            if (t > 50) begin
                $display("FAIL reset_wait_timeout: out_valid=%0d expected 1", out_valid);
                $fatal(1);
            end
        end
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        sb.delete();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        send(32'h1, 32'h20, 32'h21, 4'b1001);
        send_rand();
        drain();

        repeat (3) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
